// File: rtl/if_hazard_ctrl_if.sv
// Front-end hazard control bundle between the ID stage and the hazard controller.
// The ID side drives decode/EX info and consumes the fetch/pipe controls.
interface if_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             Branch;
    logic             Jump;
    logic             mc_start;
    logic             stat_clr;
    logic             IFWrite;
    logic             ifid_write;
    logic             IF_flush;
    logic             idex_bubble;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
        output Branch, Jump, mc_start, stat_clr,
        input  IFWrite, ifid_write, IF_flush, idex_bubble,
        input  mc_busy, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
        input  Branch, Jump, mc_start, stat_clr,
        output IFWrite, ifid_write, IF_flush, idex_bubble,
        output mc_busy, stall_count
    );
endinterface

// File: rtl/if_hazard_ctrl.sv
// Fetch/decode sequencing: load-use stalls, branch squash, multi-cycle waits.
// Also keeps a saturating count of cycles in which the PC is held.
module if_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            reset,
    if_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, MC_WAIT} state_t;

    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [CNT_W-1:0] stall_count;
    logic             lu;
    logic             ifw;
    logic             ifid;
    logic             flush;
    logic             bubble;
    logic             busy;

    assign lu = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                ((bus.ex_rd == bus.id_rs1) ||
                 (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    // State, wait counter update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and Mealy pipeline controls; reset forces a held, flushed front end.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ifw       = 1'b1;
        ifid      = 1'b1;
        flush     = 1'b0;
        bubble    = 1'b0;
        busy      = 1'b0;
        unique case (state)
            RUN: begin
                if (lu) begin
                    ifw    = 1'b0;
                    ifid   = 1'b0;
                    bubble = 1'b1;
                end else if (bus.Branch || bus.Jump) begin
                    flush = 1'b1;
                end else if (bus.mc_start) begin
                    ifw       = 1'b0;
                    ifid      = 1'b0;
                    bubble    = 1'b1;
                    cnt_nxt   = MC_INIT;
                    state_nxt = MC_WAIT;
                end
            end
            MC_WAIT: begin
                busy = 1'b1;
                if (cnt != 4'd0) begin
                    ifw     = 1'b0;
                    ifid    = 1'b0;
                    bubble  = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = RUN;
                end
            end
        endcase
        if (!reset) begin
            ifw    = 1'b0;
            ifid   = 1'b0;
            flush  = 1'b1;
            bubble = 1'b1;
            busy   = 1'b0;
        end
    end

    // Saturating count of held-PC cycles; clear wins over a same-cycle stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (bus.stat_clr) begin
            stall_count <= '0;
        end else if (!ifw && (stall_count != '1)) begin
            stall_count <= stall_count + ONE;
        end
    end

    assign bus.IFWrite     = ifw;
    assign bus.ifid_write  = ifid;
    assign bus.IF_flush    = flush;
    assign bus.idex_bubble = bubble;
    assign bus.mc_busy     = busy;
    assign bus.stall_count = stall_count;
endmodule

// File: doc/if_hazard_ctrl.md
# if_hazard_ctrl

Pipeline sequencing controller for the fetch/decode front end. It drives the PC write-enable (`IFWrite`) and IF/ID flush of the fetch stage, plus the IF/ID hold and ID/EX bubble controls. It resolves load-use hazards, taken branches/jumps and fixed-latency multi-cycle operations into stall/flush sequences. It sits beside the ID stage and also keeps a saturating count of front-end stall cycles.

## Interface

Parameters:
- `MC_LAT`, default 4: stall cycles charged to one multi-cycle op. Legal range 1..15.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`, in, 1: single clock. Rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `id_rs1`, in, 5: rs1 index of the instruction in ID.
- `id_rs2`, in, 5: rs2 index of the instruction in ID.
- `id_uses_rs2`, in, 1: the ID instruction reads rs2.
- `ex_memread`, in, 1: the EX instruction is a load.
- `ex_rd`, in, 5: destination of the EX instruction.
- `Branch`, in, 1: taken branch resolved in ID.
- `Jump`, in, 1: jump in ID.
- `mc_start`, in, 1: the ID instruction is a multi-cycle op.
- `stat_clr`, in, 1: synchronous clear of `stall_count`.
- `IFWrite`, out, 1: PC write enable to fetch.
- `ifid_write`, out, 1: IF/ID register write enable.
- `IF_flush`, out, 1: squash the IF/ID contents (insert NOP).
- `idex_bubble`, out, 1: force ID/EX control to zero.
- `mc_busy`, out, 1: multi-cycle wait in progress.
- `stall_count`, out, CNT_W: saturating count of cycles with `IFWrite`=0.

## Operation

- State register has two states, RUN and MC_WAIT. There is also a 4-bit down-counter `cnt` and the `stall_count` register.
- Load-use hazard `lu` = `ex_memread` & (`ex_rd`≠0) & ((`ex_rd`==`id_rs1`) | (`id_uses_rs2` & `ex_rd`==`id_rs2`)).
- In RUN, priority is lu > (`Branch`|`Jump`) > `mc_start`:
  - lu: `IFWrite`=0, `ifid_write`=0, `idex_bubble`=1, `IF_flush`=0. Branch, Jump and `mc_start` are ignored this cycle because the instruction re-presents. Stay in RUN.
  - `Branch`|`Jump`: `IFWrite`=1 (PC loads target), `ifid_write`=1, `IF_flush`=1, `idex_bubble`=0. Stay in RUN.
  - `mc_start`: `IFWrite`=0, `ifid_write`=0, `idex_bubble`=1. Load `cnt`←MC_LAT−1 and go to MC_WAIT.
  - Otherwise: `IFWrite`=1, `ifid_write`=1, `IF_flush`=0, `idex_bubble`=0.
- In MC_WAIT, `mc_busy`=1:
  - If `cnt`≠0: stall outputs as for `mc_start`, and `cnt`←`cnt`−1.
  - If `cnt`==0: release cycle with normal-flow outputs. lu, Branch, Jump and `mc_start` are ignored. Go to RUN.
- Outputs are combinational from state, `cnt` and inputs (Mealy). `stall_count`, `cnt` and the state are registered.
- `stall_count` increments on every edge where `IFWrite`=0 and saturates at all-ones. `stat_clr` has priority and sets it to 0.

## Timing

- Reset asserted (low), asynchronously: state=RUN, `cnt`=0, `stall_count`=0.
- Outputs while reset is asserted: `IFWrite`=0, `ifid_write`=0, `IF_flush`=1, `idex_bubble`=1, `mc_busy`=0.
- After reset release, the first edge is a normal RUN cycle.
- Reset mid-MC_WAIT aborts the wait immediately. No release cycle occurs.
- Load-use costs exactly 1 stall cycle; the hazard clears because the bubble enters EX.
- Branch/Jump costs 1 squashed slot and no stall.
- `mc_start` costs exactly MC_LAT stall cycles. The op leaves ID on cycle MC_LAT+1 counted from the `mc_start` cycle.
- With MC_LAT=1, MC_WAIT lasts one cycle and that cycle is the release cycle.
- `mc_busy` is high for MC_LAT cycles, starting the cycle after `mc_start`.
- A stall cycle (`IFWrite`=0) is visible in `stall_count` on the following edge.
- `stat_clr` in the same cycle as a stall gives `stall_count`=0.

## Test plan

- Reset hold then release, no hazards: outputs reset to 0/0/1/1/0. Afterwards `IFWrite`=`ifid_write`=1 and `stall_count` stays 0 after 10 cycles.
- Load-use: `ex_memread`=1, `ex_rd`=5, `id_rs1`=5. Expect one cycle of `IFWrite`=0, `idex_bubble`=1, then normal flow and `stall_count`=1. Repeat with `ex_rd`=0: no stall.
- rs2 gating: `ex_rd`=7, `id_rs2`=7, `id_uses_rs2`=0 gives no stall; with `id_uses_rs2`=1, one stall.
- Branch with load-use in the same cycle: the stall wins and `IF_flush`=0. On the next cycle, with Branch held and lu cleared, `IF_flush`=1 and `IFWrite`=1.
- MC_LAT=4, `mc_start` pulse: `IFWrite`=0 for exactly 4 cycles, then 1 on the 5th. `mc_busy` is high on cycles 2–5 and `stall_count`=4.
- Reset asserted on cycle 2 of MC_WAIT: the state returns to RUN with no release cycle and `stall_count`=0. Also check saturation by forcing the count to all-ones and applying a stall: the value holds.
